// File: rtl/stack_pshpul_seq.sv
// Push/pull sequencer for PSHS/PSHU/PULS/PULU and interrupt-frame stacking.
// Walks a postbyte register mask, moving one byte per accepted bus cycle.
module stack_pshpul_seq (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        start,
    input  logic        push,
    input  logic        use_s,
    input  logic [7:0]  postbyte,
    input  logic [15:0] reg_su,
    input  logic [15:0] reg_data,
    input  logic [7:0]  mem_data_in,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic        su_sel,
    output logic [3:0]  reg_read_addr,
    output logic [3:0]  write_reg_addr,
    output logic        write_pull_reg,
    output logic [15:0] data_w,
    output logic        inc_su,
    output logic        dec_su,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data_out,
    output logic        mem_we,
    output logic        mem_re
);

    typedef enum logic [1:0] {IDLE, BYTE, WB, DONE} state_t;

    state_t      state, state_nx;
    logic [7:0]  mask, mask_nx;
    logic        hi_byte, hi_nx;
    logic        push_l, push_nx;
    logic        su_l, su_nx;
    logic [7:0]  lat, wb_byte;
    logic        lat_ld, wb_ld;

    logic [2:0]  cur_bit;
    logic [3:0]  cur_code;
    logic        cur_wide;
    logic [7:0]  cur_clr;

    // Push walks PC first (highest bit); pull walks CC first (lowest bit).
    function automatic logic [2:0] top_bit(input logic [7:0] m);
        top_bit = 3'd0;
        for (int i = 0; i < 8; i++)
            if (m[i]) top_bit = 3'(i);
    endfunction

    function automatic logic [2:0] bot_bit(input logic [7:0] m);
        bot_bit = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) bot_bit = 3'(i);
    endfunction

    function automatic logic [3:0] reg_code(input logic [2:0] b, input logic s);
        case (b)
            3'd7:    reg_code = 4'd5;
            3'd6:    reg_code = s ? 4'd3 : 4'd4;
            3'd5:    reg_code = 4'd2;
            3'd4:    reg_code = 4'd1;
            3'd3:    reg_code = 4'd11;
            3'd2:    reg_code = 4'd9;
            3'd1:    reg_code = 4'd8;
            default: reg_code = 4'd10;
        endcase
    endfunction

    assign cur_bit  = push_l ? top_bit(mask) : bot_bit(mask);
    assign cur_code = reg_code(cur_bit, su_l);
    assign cur_wide = cur_bit[2];
    assign cur_clr  = mask & ~(8'd1 << cur_bit);
    assign su_sel   = su_l;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            mask    <= 8'h00;
            hi_byte <= 1'b0;
            push_l  <= 1'b0;
            su_l    <= 1'b0;
        end else begin
            state   <= state_nx;
            mask    <= mask_nx;
            hi_byte <= hi_nx;
            push_l  <= push_nx;
            su_l    <= su_nx;
        end
    end

    // Byte holding registers only feed data_w in WB, so they need no reset.
    always_ff @(posedge clk_in) begin
        if (lat_ld) lat     <= mem_data_in;
        if (wb_ld)  wb_byte <= mem_data_in;
    end

    always_comb begin
        state_nx       = state;
        mask_nx        = mask;
        hi_nx          = hi_byte;
        push_nx        = push_l;
        su_nx          = su_l;
        lat_ld         = 1'b0;
        wb_ld          = 1'b0;
        busy           = (state != IDLE);
        done           = 1'b0;
        reg_read_addr  = 4'd0;
        write_reg_addr = 4'd0;
        write_pull_reg = 1'b0;
        data_w         = 16'h0000;
        inc_su         = 1'b0;
        dec_su         = 1'b0;
        mem_addr       = 16'h0000;
        mem_data_out   = 8'h00;
        mem_we         = 1'b0;
        mem_re         = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    mask_nx  = postbyte;
                    push_nx  = push;
                    su_nx    = use_s;
                    hi_nx    = 1'b0;
                    state_nx = (postbyte == 8'h00) ? DONE : BYTE;
                end
            end
            BYTE: begin
                if (push_l) begin
                    reg_read_addr = cur_code;
                    mem_we        = 1'b1;
                    mem_addr      = reg_su - 16'd1;
                    mem_data_out  = hi_byte ? reg_data[15:8] : reg_data[7:0];
                    if (mem_ready) begin
                        dec_su = 1'b1;
                        if (cur_wide && !hi_byte) begin
                            hi_nx = 1'b1;
                        end else begin
                            hi_nx   = 1'b0;
                            mask_nx = cur_clr;
                            if (cur_clr == 8'h00) state_nx = DONE;
                        end
                    end
                end else begin
                    mem_re   = 1'b1;
                    mem_addr = reg_su;
                    if (mem_ready) begin
                        inc_su = 1'b1;
                        if (cur_wide && !hi_byte) begin
                            hi_nx  = 1'b1;
                            lat_ld = 1'b1;
                        end else begin
                            hi_nx    = 1'b0;
                            wb_ld    = 1'b1;
                            state_nx = WB;
                        end
                    end
                end
            end
            WB: begin
                write_pull_reg = 1'b1;
                write_reg_addr = cur_code;
                data_w         = cur_wide ? {lat, wb_byte} : {8'h00, wb_byte};
                mask_nx        = cur_clr;
                state_nx       = (cur_clr != 8'h00) ? BYTE : DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_stack_pshpul_seq.sv
// Bench for stack_pshpul_seq: register-block/memory environment, a byte-level
// transaction model of each sequence, and one per-cycle compare process.
module tb_stack_pshpul_seq;

    localparam int EV_W = 0;
    localparam int EV_R = 1;
    localparam int EV_G = 2;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        reset_n, start, push, use_s, mem_ready;
    logic [7:0]  postbyte, mem_data_in;
    logic [15:0] reg_su, reg_data;
    logic        busy, done, su_sel, write_pull_reg, inc_su, dec_su, mem_we, mem_re;
    logic [3:0]  reg_read_addr, write_reg_addr;
    logic [15:0] data_w, mem_addr;
    logic [7:0]  mem_data_out;

    stack_pshpul_seq dut (
        .clk_in(clk_in), .reset_n(reset_n), .start(start), .push(push), .use_s(use_s),
        .postbyte(postbyte), .reg_su(reg_su), .reg_data(reg_data),
        .mem_data_in(mem_data_in), .mem_ready(mem_ready), .busy(busy), .done(done),
        .su_sel(su_sel), .reg_read_addr(reg_read_addr), .write_reg_addr(write_reg_addr),
        .write_pull_reg(write_pull_reg), .data_w(data_w), .inc_su(inc_su), .dec_su(dec_su),
        .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_we(mem_we), .mem_re(mem_re)
    );

    // Environment: register block and memory
    logic [15:0] rf [0:15];
    logic [7:0]  mem [0:65535];
    int          pl_kind = 0;
    logic [15:0] pl_addr, pl_val;

    assign reg_su      = su_sel ? rf[4] : rf[3];
    assign reg_data    = rf[reg_read_addr];
    assign mem_data_in = mem[mem_addr];

    always @(posedge clk_in) begin
        if (pl_kind == 1) rf[pl_addr[3:0]] <= pl_val;
        else if (pl_kind == 2) mem[pl_addr] <= pl_val[7:0];
        if (dec_su) rf[su_sel ? 4'd4 : 4'd3] <= reg_su - 16'd1;
        if (inc_su) rf[su_sel ? 4'd4 : 4'd3] <= reg_su + 16'd1;
        if (write_pull_reg) rf[write_reg_addr] <= data_w;
        if (mem_we && mem_ready) mem[mem_addr] <= mem_data_out;
    end

    // Expected transaction list, owned by the stimulus process
    int          exp_kind [0:31];
    logic [15:0] exp_addr [0:31];
    logic [15:0] exp_val  [0:31];
    logic [3:0]  exp_code [0:31];
    int          exp_n = 0;
    int          seq_id = 0;

    int          req_seq = 0;
    string       req_name = "";
    logic [31:0] req_act, req_exp;

    // Owned by the compare process
    int checks, errors, rd_idx, cur_seq, seen_seq;
    int n_dec, n_inc, n_we, n_re, n_wpr;
    logic        prev_stall, prev_we, prev_re;
    logic [15:0] prev_addr;
    logic [7:0]  prev_data;

    function automatic logic [3:0] code_of(input int b, input logic s);
        case (b)
            7: code_of = 4'd5;
            6: code_of = s ? 4'd3 : 4'd4;
            5: code_of = 4'd2;
            4: code_of = 4'd1;
            3: code_of = 4'd11;
            2: code_of = 4'd9;
            1: code_of = 4'd8;
            default: code_of = 4'd10;
        endcase
    endfunction

    task automatic add_ev(input int k, input logic [15:0] a, input logic [15:0] v, input logic [3:0] c);
        exp_kind[exp_n] = k;
        exp_addr[exp_n] = a;
        exp_val[exp_n]  = v;
        exp_code[exp_n] = c;
        exp_n++;
    endtask

    // Byte order on the stack: pushes go down, low byte first; pulls go up, high byte first.
    task automatic build_exp(input logic p, input logic s, input logic [7:0] pb);
        logic [15:0] sp, v;
        logic [3:0]  c;
        exp_n = 0;
        sp = s ? rf[4] : rf[3];
        if (p) begin
            for (int b = 7; b >= 0; b--) begin
                if (pb[b]) begin
                    c = code_of(b, s);
                    v = rf[c];
                    add_ev(EV_W, sp - 16'd1, {8'h00, v[7:0]}, 4'd0);
                    sp = sp - 16'd1;
                    if (b >= 4) begin
                        add_ev(EV_W, sp - 16'd1, {8'h00, v[15:8]}, 4'd0);
                        sp = sp - 16'd1;
                    end
                end
            end
        end else begin
            for (int b = 0; b < 8; b++) begin
                if (pb[b]) begin
                    c = code_of(b, s);
                    if (b >= 4) begin
                        add_ev(EV_R, sp, 16'h0000, 4'd0);
                        add_ev(EV_R, sp + 16'd1, 16'h0000, 4'd0);
                        add_ev(EV_G, 16'h0000, {mem[sp], mem[sp + 16'd1]}, c);
                        sp = sp + 16'd2;
                    end else begin
                        add_ev(EV_R, sp, 16'h0000, 4'd0);
                        add_ev(EV_G, 16'h0000, {8'h00, mem[sp]}, c);
                        sp = sp + 16'd1;
                    end
                end
            end
        end
    endtask

    // Compare process: the only writer of checks/errors
    initial begin
        checks = 0; errors = 0; rd_idx = 0; cur_seq = 0; seen_seq = 0;
        n_dec = 0; n_inc = 0; n_we = 0; n_re = 0; n_wpr = 0;
        prev_stall = 1'b0; prev_we = 1'b0; prev_re = 1'b0; prev_addr = 16'h0; prev_data = 8'h0;
        forever begin
            @(negedge clk_in);
            if (req_seq != seen_seq) begin
                seen_seq = req_seq;
                checks++;
                if (req_act !== req_exp) begin
                    errors++;
                    $display("FAIL %s: got %0h, want %0h", req_name, req_act, req_exp);
                end
            end
            if (!reset_n) begin
                checks++;
                if ({busy, done, su_sel, reg_read_addr, write_reg_addr, write_pull_reg, data_w,
                     inc_su, dec_su, mem_addr, mem_data_out, mem_we, mem_re} !== 56'd0) begin
                    errors++;
                    $display("FAIL reset_outputs: busy=%b done=%b addr=%h dw=%h we=%b re=%b wpr=%b rra=%h, want all 0",
                             busy, done, mem_addr, data_w, mem_we, mem_re, write_pull_reg, reg_read_addr);
                end
                prev_stall = 1'b0;
            end else begin
                if (seq_id != cur_seq) begin
                    cur_seq = seq_id;
                    rd_idx = 0;
                end
                checks++;
                if (dec_su !== (mem_we & mem_ready) || inc_su !== (mem_re & mem_ready)) begin
                    errors++;
                    $display("FAIL step_rule: inc=%b dec=%b we=%b re=%b rdy=%b", inc_su, dec_su, mem_we, mem_re, mem_ready);
                end
                checks++;
                if ($countones({inc_su, dec_su, write_pull_reg}) > 1) begin
                    errors++;
                    $display("FAIL exclusive: inc=%b dec=%b wpr=%b, want at most one", inc_su, dec_su, write_pull_reg);
                end
                if (!busy) begin
                    checks++;
                    if ({mem_we, mem_re, write_pull_reg, inc_su, dec_su, done} !== 6'd0) begin
                        errors++;
                        $display("FAIL idle_quiet: strobes=%b, want 000000", {mem_we, mem_re, write_pull_reg, inc_su, dec_su, done});
                    end
                end
                if (prev_stall) begin
                    checks++;
                    if (mem_addr !== prev_addr || mem_we !== prev_we || mem_re !== prev_re ||
                        (prev_we && mem_data_out !== prev_data)) begin
                        errors++;
                        $display("FAIL stall_hold: addr=%h data=%h we=%b re=%b, want addr=%h data=%h we=%b re=%b",
                                 mem_addr, mem_data_out, mem_we, mem_re, prev_addr, prev_data, prev_we, prev_re);
                    end
                end
                if (mem_we && mem_ready) begin
                    checks++;
                    if (!(rd_idx < exp_n && exp_kind[rd_idx] == EV_W && exp_addr[rd_idx] === mem_addr &&
                          exp_val[rd_idx][7:0] === mem_data_out)) begin
                        errors++;
                        $display("FAIL mem_write[%0d]: addr=%h data=%h, want addr=%h data=%h", rd_idx, mem_addr,
                                 mem_data_out, exp_addr[rd_idx < 32 ? rd_idx : 0], exp_val[rd_idx < 32 ? rd_idx : 0]);
                    end
                    if (rd_idx < 32) rd_idx++;
                end
                if (mem_re && mem_ready) begin
                    checks++;
                    if (!(rd_idx < exp_n && exp_kind[rd_idx] == EV_R && exp_addr[rd_idx] === mem_addr)) begin
                        errors++;
                        $display("FAIL mem_read[%0d]: addr=%h, want %h", rd_idx, mem_addr, exp_addr[rd_idx < 32 ? rd_idx : 0]);
                    end
                    if (rd_idx < 32) rd_idx++;
                end
                if (write_pull_reg) begin
                    checks++;
                    if (!(rd_idx < exp_n && exp_kind[rd_idx] == EV_G && exp_code[rd_idx] === write_reg_addr &&
                          exp_val[rd_idx] === data_w)) begin
                        errors++;
                        $display("FAIL reg_write[%0d]: reg=%0d data=%h, want reg=%0d data=%h", rd_idx, write_reg_addr,
                                 data_w, exp_code[rd_idx < 32 ? rd_idx : 0], exp_val[rd_idx < 32 ? rd_idx : 0]);
                    end
                    if (rd_idx < 32) rd_idx++;
                end
                prev_stall = (mem_we || mem_re) && !mem_ready;
                prev_addr  = mem_addr;
                prev_data  = mem_data_out;
                prev_we    = mem_we;
                prev_re    = mem_re;
                if (dec_su) n_dec++;
                if (inc_su) n_inc++;
                if (mem_we) n_we++;
                if (mem_re) n_re++;
                if (write_pull_reg) n_wpr++;
            end
        end
    end

    task automatic expect_eq(input string nm, input logic [31:0] act, input logic [31:0] want);
        req_name = nm;
        req_act  = act;
        req_exp  = want;
        req_seq++;
        @(negedge clk_in);
        #1;
    endtask

    task automatic set_reg(input logic [3:0] c, input logic [15:0] v);
        pl_kind = 1; pl_addr = {12'h000, c}; pl_val = v;
        @(posedge clk_in); #1;
        pl_kind = 0;
    endtask

    task automatic set_mem(input logic [15:0] a, input logic [7:0] v);
        pl_kind = 2; pl_addr = a; pl_val = {8'h00, v};
        @(posedge clk_in); #1;
        pl_kind = 0;
    endtask

    task automatic run_seq(input logic p, input logic s, input logic [7:0] pb, input int stall,
                           input int exp_cyc, input logic poke, input string nm);
        int k;
        build_exp(p, s, pb);
        seq_id++;
        push = p; use_s = s; postbyte = pb; start = 1'b1;
        @(posedge clk_in); #1;
        start = 1'b0;
        k = 0;
        for (int c = 1; c <= 60; c++) begin
            mem_ready = (c > stall);
            if (poke && c == 3) begin start = 1'b1; postbyte = 8'h00; end
            if (poke && c == 4) start = 1'b0;
            if (done) begin k = c; break; end
            @(posedge clk_in); #1;
        end
        start = 1'b0;
        mem_ready = 1'b1;
        expect_eq({nm, "_done_cycle"}, k, exp_cyc);
        @(posedge clk_in); #1;
        expect_eq({nm, "_busy_low"}, {31'd0, busy}, 32'd0);
        expect_eq({nm, "_all_events"}, rd_idx, exp_n);
    endtask

    int d_dec, d_inc, d_we, d_re, d_wpr;

    task automatic snap();
        d_dec = n_dec; d_inc = n_inc; d_we = n_we; d_re = n_re; d_wpr = n_wpr;
    endtask

    initial begin
        reset_n = 1'b1; start = 1'b0; push = 1'b0; use_s = 1'b0; postbyte = 8'h00; mem_ready = 1'b1;
        #2 reset_n = 1'b0;
        set_reg(4'd5, 16'hA1B2); set_reg(4'd3, 16'hC3D4); set_reg(4'd2, 16'h5566);
        set_reg(4'd1, 16'h7788); set_reg(4'd11, 16'h0099); set_reg(4'd9, 16'h00AA);
        set_reg(4'd8, 16'h00BB); set_reg(4'd10, 16'h00CC); set_reg(4'd4, 16'h0F00);
        @(posedge clk_in); #1 reset_n = 1'b1;

        // Push everything onto S, with a start pulse mid-sequence that must be ignored
        snap();
        run_seq(1'b1, 1'b1, 8'hFF, 0, 13, 1'b1, "push_all");
        expect_eq("push_all_dec", n_dec - d_dec, 12);
        expect_eq("push_all_mem_0EFF", {24'd0, mem[16'h0EFF]}, 32'hB2);
        expect_eq("push_all_mem_0EFE", {24'd0, mem[16'h0EFE]}, 32'hA1);
        expect_eq("push_all_mem_0EFD", {24'd0, mem[16'h0EFD]}, 32'hD4);
        expect_eq("push_all_mem_0EF4", {24'd0, mem[16'h0EF4]}, 32'hCC);
        expect_eq("push_all_s", {16'd0, rf[4]}, 32'h0EF4);

        // Pull CC then PC from U
        set_reg(4'd3, 16'h0E00);
        set_mem(16'h0E00, 8'h5A); set_mem(16'h0E01, 8'h12); set_mem(16'h0E02, 8'h34);
        snap();
        run_seq(1'b0, 1'b0, 8'h81, 0, 6, 1'b0, "pull_81");
        expect_eq("pull_81_inc", n_inc - d_inc, 3);
        expect_eq("pull_81_cc", {16'd0, rf[10]}, 32'h005A);
        expect_eq("pull_81_pc", {16'd0, rf[5]}, 32'h1234);
        expect_eq("pull_81_u", {16'd0, rf[3]}, 32'h0E03);

        // Empty mask: straight to DONE with no activity
        snap();
        run_seq(1'b0, 1'b1, 8'h00, 0, 1, 1'b0, "empty");
        expect_eq("empty_activity", (n_dec - d_dec) + (n_inc - d_inc) + (n_we - d_we) + (n_re - d_re) + (n_wpr - d_wpr), 0);

        // Push A with three wait states
        snap();
        run_seq(1'b1, 1'b1, 8'h02, 3, 5, 1'b0, "stall_a");
        expect_eq("stall_a_dec", n_dec - d_dec, 1);
        expect_eq("stall_a_we_cycles", n_we - d_we, 4);
        expect_eq("stall_a_mem", {24'd0, mem[16'h0EF3]}, 32'hBB);

        // Pull X across the top of the address space
        set_reg(4'd4, 16'hFFFF);
        set_mem(16'hFFFF, 8'hAB); set_mem(16'h0000, 8'hCD);
        run_seq(1'b0, 1'b1, 8'h10, 0, 4, 1'b0, "wrap_x");
        expect_eq("wrap_x_val", {16'd0, rf[1]}, 32'hABCD);
        expect_eq("wrap_x_s", {16'd0, rf[4]}, 32'h0001);

        // Reset between the high and low bytes of a pulled X
        set_reg(4'd4, 16'h2000); set_reg(4'd1, 16'h0BAD);
        set_mem(16'h2000, 8'h11); set_mem(16'h2001, 8'h22);
        snap();
        build_exp(1'b0, 1'b1, 8'h10);
        seq_id++;
        push = 1'b0; use_s = 1'b1; postbyte = 8'h10; start = 1'b1;
        @(posedge clk_in); #1 start = 1'b0;
        @(posedge clk_in); #1;
        reset_n = 1'b0;
        #1;
        exp_n = 0;
        seq_id++;
        expect_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(posedge clk_in); #1 reset_n = 1'b1;
        @(posedge clk_in); #1;
        expect_eq("rst_mid_no_write", n_wpr - d_wpr, 0);
        expect_eq("rst_mid_x_kept", {16'd0, rf[1]}, 32'h0BAD);
        expect_eq("rst_mid_s", {16'd0, rf[4]}, 32'h2001);
        run_seq(1'b0, 1'b1, 8'h02, 0, 3, 1'b0, "after_rst");
        expect_eq("after_rst_a", {16'd0, rf[8]}, 32'h0022);
        expect_eq("after_rst_s", {16'd0, rf[4]}, 32'h2002);

        @(negedge clk_in); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_pshpul_seq.md
# stack_pshpul_seq

Push/pull sequencer for the 6809 core's PSHS/PSHU/PULS/PULU and interrupt-frame stacking. It walks a postbyte register mask and moves one byte per accepted bus cycle. On push it reads registers from the register block's left read path and writes them to memory. On pull it reads memory and writes the register block through its `write_pull_reg` port, stepping S or U via `inc_su`/`dec_su`.

## Interface
Parameters: none.

Ports:
- `clk_in` in 1: core clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a sequence; sampled only in IDLE.
- `push` in 1: 1 = push to memory, 0 = pull from memory; latched at start.
- `use_s` in 1: 1 = S is the stack, 0 = U; latched at start.
- `postbyte` in 8: register mask; b7 PC, b6 other stack pointer (U if `use_s`, else S), b5 Y, b4 X, b3 DP, b2 B, b1 A, b0 CC.
- `reg_su` in 16: current stack pointer from the register block.
- `reg_data` in 16: left read path data.
- `mem_data_in` in 8: read data; valid while `mem_ready` is high.
- `mem_ready` in 1: completes the current bus cycle.
- `busy` out 1: high from the cycle after start through the DONE cycle.
- `done` out 1: one-cycle pulse in the DONE state.
- `su_sel` out 1: latched `use_s`; drives the register block's `use_s`.
- `reg_read_addr` out 4: left read path select.
- `write_reg_addr` out 4: register write select.
- `write_pull_reg` out 1: register write strobe.
- `data_w` out 16: register write data.
- `inc_su`, `dec_su` out 1: stack pointer step strobes.
- `mem_addr` out 16: byte address.
- `mem_data_out` out 8: write data.
- `mem_we`, `mem_re` out 1: bus cycle strobes.

Register codes are shared by `reg_read_addr` and `write_reg_addr`: 0 D, 1 X, 2 Y, 3 U, 4 S, 5 PC, 8 A, 9 B, 10 CC, 11 DP.

## Operation
- State is `mask[7:0]`, `hi_byte`, a pull byte latch `lat[7:0]`, and the FSM. FSM states: IDLE, BYTE, WB, DONE.
- **Current register**:
  - Push: highest set bit of `mask`, order PC, S/U, Y, X, DP, B, A, CC.
  - Pull: lowest set bit, reverse order.
  - Registers of 16 bits are PC, S/U, Y, X. Registers of 8 bits are DP, B, A, CC.
- **Push, BYTE state**:
  - `reg_read_addr` = current register; `mem_we` = 1; `mem_addr` = `reg_su` - 1 (16-bit wrap).
  - `mem_data_out` = `reg_data[7:0]` for 8-bit registers and for the first (low) byte of 16-bit registers. It is `reg_data[15:8]` for the second byte.
  - On `mem_ready`: assert `dec_su` that cycle. For a 16-bit register with `hi_byte` = 0, set `hi_byte`. Otherwise clear the mask bit and `hi_byte`.
  - When the mask empties, go to DONE; otherwise stay in BYTE.
  - Memory image ends up big-endian: high byte at the lower address.
- **Pull, BYTE state**:
  - `mem_re` = 1; `mem_addr` = `reg_su`.
  - On `mem_ready`: assert `inc_su`. For a 16-bit register, the first byte goes to `lat` (high byte); the second byte goes to WB.
  - For an 8-bit register, the byte goes to WB.
- **WB state** (one cycle):
  - `write_pull_reg` = 1; `write_reg_addr` = current register.
  - `data_w` = {`lat`, second byte} for 16-bit registers, or {8'h00, byte} for 8-bit registers. The WB data byte is held in an internal register.
  - Clear the mask bit. Go to BYTE if the mask is still non-zero, otherwise DONE.
- **DONE**: `done` = 1 for one cycle, then IDLE.
- **start in IDLE**: latch `postbyte`, `push` and `use_s`, then go to BYTE. If `postbyte` is 0x00, go straight to DONE with no bus, step or write activity.
- **Stalls**: while `mem_ready` = 0 in BYTE, hold `mem_addr`, `mem_data_out` and the strobe stable, and assert no step strobe.
- **Exclusivity**: `inc_su`, `dec_su` and `write_pull_reg` are never high in the same cycle. `start` while busy is ignored.
- **Reset**: on `reset_n` low, at any time including mid-sequence, all outputs go to 0 immediately and the FSM goes to IDLE. A partially pulled 16-bit register is not written.

## Timing
- Reset values: every output is 0, including `data_w`, `mem_addr` and `reg_read_addr`.
- Strobes are Moore outputs of BYTE/WB, except the step strobes, which are gated combinationally by `mem_ready`.
- `start` at edge E0 puts BYTE in the cycle after E0.
- Push cost (`mem_ready` held high): one cycle per byte. `done` lands in the cycle after the last byte.
- Pull cost: 8-bit register = 2 cycles; 16-bit register = 3 cycles. `done` lands in the cycle after the last WB.
- `busy` falls in the cycle after DONE. A new `start` is accepted in that cycle.
- `reg_su` is consumed combinationally, so each access uses the value already stepped at the preceding edge.

## Test plan
- **Push all, S = 0x0F00, postbyte 0xFF, `mem_ready` high**:
  - 12 writes, `mem_addr` 0x0EFF down to 0x0EF4, in order PCL, PCH, UL, UH, YL, YH, XL, XH, DP, B, A, CC.
  - 12 `dec_su` pulses; `done` in cycle 13 after start.
- **Pull postbyte 0x81, U = 0x0E00, memory 0x0E00..0x0E02 = 0x5A, 0x12, 0x34**:
  - CC written 0x005A, then PC written 0x1234.
  - 3 `inc_su` pulses; `done` in cycle 6.
- **postbyte 0x00**: `done` in the cycle after start; no `mem_we`, `mem_re`, step or write strobes.
- **Push A (0x02) with `mem_ready` low for 3 cycles**: `mem_we` and `mem_addr` = S-1 held for 4 cycles; exactly one `dec_su`, on the accepting cycle.
- **Stack wrap**: pull 16-bit X with S = 0xFFFF reads 0xFFFF then 0x0000.
- **Reset mid-pull**: `reset_n` low between the X high and low bytes gives all outputs 0 immediately and no `write_pull_reg`. The block is back in IDLE and accepts `start` after release.
